// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory-port arbiter: default widths, FSM state
// encoding and the owner encoding used by the arbitration logic.
package mem_arb_pkg;

   localparam int DEF_ADDR_W = 28;
   localparam int DEF_DATA_W = 128;

   localparam logic [1:0] STATE_IDLE    = 2'd0;
   localparam logic [1:0] STATE_GRANT_I = 2'd1;
   localparam logic [1:0] STATE_GRANT_D = 2'd2;

   localparam logic OWNER_I = 1'b0;
   localparam logic OWNER_D = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE    = STATE_IDLE,
      ST_GRANT_I = STATE_GRANT_I,
      ST_GRANT_D = STATE_GRANT_D
   } state_e;

   // Maps a chosen owner to the grant state it leads to.
   function automatic state_e grant_state(input logic owner);
      return (owner == OWNER_D) ? ST_GRANT_D : ST_GRANT_I;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of I-cache, D-cache and memory-port signals around the arbiter.
// The master modport is the arbiter's view; slave is the surrounding system.
interface mem_arbiter_if #(
   parameter int ADDR_W = mem_arb_pkg::DEF_ADDR_W,
   parameter int DATA_W = mem_arb_pkg::DEF_DATA_W
) ();

   logic              ic_read_i;
   logic [ADDR_W-1:0] ic_addr_i;
   logic [DATA_W-1:0] ic_rdata_o;
   logic              ic_ready_o;

   logic              dc_read_i;
   logic              dc_write_i;
   logic [ADDR_W-1:0] dc_addr_i;
   logic [DATA_W-1:0] dc_wdata_i;
   logic [DATA_W-1:0] dc_rdata_o;
   logic              dc_ready_o;

   logic              mem_read_o;
   logic              mem_write_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_wdata_o;
   logic [DATA_W-1:0] mem_rdata_i;
   logic              mem_ready_i;

   modport master (
      input  ic_read_i, ic_addr_i,
      input  dc_read_i, dc_write_i, dc_addr_i, dc_wdata_i,
      input  mem_rdata_i, mem_ready_i,
      output ic_rdata_o, ic_ready_o,
      output dc_rdata_o, dc_ready_o,
      output mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o
   );

   modport slave (
      output ic_read_i, ic_addr_i,
      output dc_read_i, dc_write_i, dc_addr_i, dc_wdata_i,
      output mem_rdata_i, mem_ready_i,
      input  ic_rdata_o, ic_ready_o,
      input  dc_rdata_o, dc_ready_o,
      input  mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o
   );

endinterface

// File: rtl/mem_arb_pick.sv
// Two-requester selector: a lone requester wins outright; on a tie the
// requester that did not own the port last time wins.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic ic_req,
   input  logic dc_req,
   input  logic last_owner,
   output logic grant_valid,
   output logic grant_owner
);

   always_comb begin
      grant_valid = ic_req | dc_req;
      if (ic_req && dc_req) begin
         grant_owner = ~last_owner;
      end else if (dc_req) begin
         grant_owner = OWNER_D;
      end else begin
         grant_owner = OWNER_I;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the off-chip memory line port between the I-cache and D-cache.
// Build option MEM_ARB_ROUND_ROBIN_EN: alternate owners on ties instead of D-first.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic          clk,
   input  logic          proc_reset_i,
   mem_arbiter_if.master bus
);

   localparam logic [ADDR_W-1:0] ZERO_ADDR = '0;
   localparam logic [DATA_W-1:0] ZERO_DATA = '0;

   state_e state;
   logic   ic_req;
   logic   dc_req;
   logic   last_owner;
   logic   grant_valid;
   logic   grant_owner;

   assign ic_req = bus.ic_read_i;
   assign dc_req = bus.dc_read_i | bus.dc_write_i;

   mem_arb_pick u_pick (
      .ic_req      (ic_req),
      .dc_req      (dc_req),
      .last_owner  (last_owner),
      .grant_valid (grant_valid),
      .grant_owner (grant_owner)
   );

   // A grant ends on completion or when its requester withdraws; either way the
   // FSM passes through IDLE so the memory sees a deasserted request in between.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      if (proc_reset_i) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (grant_valid) begin
                  state <= grant_state(grant_owner);
               end
            end
            ST_GRANT_I: begin
               if (bus.mem_ready_i || !ic_req) begin
                  state <= ST_IDLE;
               end
            end
            ST_GRANT_D: begin
               if (bus.mem_ready_i || !dc_req) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef MEM_ARB_ROUND_ROBIN_EN
   always_ff @(posedge clk) begin
      if (proc_reset_i) begin
         last_owner <= OWNER_I;
      end else if (bus.mem_ready_i && state == ST_GRANT_I) begin
         last_owner <= OWNER_I;
      end else if (bus.mem_ready_i && state == ST_GRANT_D) begin
         last_owner <= OWNER_D;
      end
   end
`else
   // Pinning last_owner to I makes every tie resolve to D: fixed D-over-I priority.
   assign last_owner = OWNER_I;
`endif

   // Strobes follow the owner's live request so a withdrawn request drops them at once.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      bus.mem_read_o  = 1'b0;
      bus.mem_write_o = 1'b0;
      bus.mem_addr_o  = ZERO_ADDR;
      bus.mem_wdata_o = ZERO_DATA;
      bus.ic_ready_o  = 1'b0;
      bus.dc_ready_o  = 1'b0;
      case (state)
         ST_GRANT_I: begin
            bus.mem_read_o = bus.ic_read_i;
            bus.mem_addr_o = bus.ic_addr_i;
            // A completion that coincides with reset is not reported.
            bus.ic_ready_o = bus.mem_ready_i & ~proc_reset_i;
         end
         ST_GRANT_D: begin
            bus.mem_read_o  = bus.dc_read_i;
            bus.mem_write_o = bus.dc_write_i;
            bus.mem_addr_o  = bus.dc_addr_i;
            bus.mem_wdata_o = bus.dc_wdata_i;
            bus.dc_ready_o  = bus.mem_ready_i & ~proc_reset_i;
         end
         default: ;
      endcase
   end

   assign bus.ic_rdata_o = bus.mem_rdata_i;
   assign bus.dc_rdata_o = bus.mem_rdata_i;

   // The D-cache never issues read and write together; the arbiter would forward both.
   a_dc_one_op: assert property (@(posedge clk) disable iff (proc_reset_i)
      !(bus.dc_read_i && bus.dc_write_i));

endmodule
